// File: rtl/serial_magnitude_comparator.sv
`default_nettype none
// ============================================================================
// Module  : serial_magnitude_comparator
// Brief   : MSB-first digit-serial magnitude compare with early termination,
//           unsigned or two's-complement per operation, start/done handshake.
// Revision: 1.0  initial release
// ============================================================================
module serial_magnitude_comparator #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int            N    = WIDTH / DIGIT;
  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] load_a;
  logic [WIDTH-1:0] load_b;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] dig_a;
  logic [DIGIT-1:0] dig_b;

  // Flipping the sign bit maps two's-complement onto offset binary, so the
  // scan itself is always unsigned.
  always_comb begin
    load_a            = a;
    load_b            = b;
    load_a[WIDTH-1]   = a[WIDTH-1] ^ signed_mode;
    load_b[WIDTH-1]   = b[WIDTH-1] ^ signed_mode;
  end

  assign dig_a = sh_a[WIDTH-1 -: DIGIT];
  assign dig_b = sh_b[WIDTH-1 -: DIGIT];
  assign busy  = (state == SCAN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sh_a  <= '0;
      sh_b  <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      gt    <= 1'b0;
      eq    <= 1'b0;
      lt    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sh_a  <= load_a;
            sh_b  <= load_b;
            cnt   <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (dig_a != dig_b) begin
            state <= IDLE;
            done  <= 1'b1;
            gt    <= (dig_a > dig_b);
            eq    <= 1'b0;
            lt    <= (dig_a < dig_b);
          end else if (cnt == LAST) begin
            state <= IDLE;
            done  <= 1'b1;
            gt    <= 1'b0;
            eq    <= 1'b1;
            lt    <= 1'b0;
          end else begin
            sh_a <= sh_a << DIGIT;
            sh_b <= sh_b << DIGIT;
            cnt  <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
